// File: rtl/secuenciador_alu.sv
// Byte-stream sequencer: loads A, B and opcode into the ALU handler and returns the result byte.
// Optional inter-byte timeout enabled by defining SEC_TIMEOUT_EN.
module secuenciador_alu #(
  parameter int nbits    = 8,
  parameter int RES_WAIT = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [nbits-1:0] rx_data,
  input  logic             rx_valid,
  output logic [2:0]       p_abc,
  output logic [nbits-1:0] buf_out,
  input  logic [nbits-1:0] dato_R,
  output logic [nbits-1:0] tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic             err_ovr,
  output logic             err_tmo
);

  localparam int WW = (RES_WAIT > 1) ? $clog2(RES_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    ESP_A   = 3'd0,
    ESP_B   = 3'd1,
    ESP_OP  = 3'd2,
    ESP_ALU = 3'd3,
    ENVIAR  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [WW-1:0]     wait_reg, wait_next;
  logic [2:0]        p_abc_next;
  logic [nbits-1:0]  buf_next;
  logic [nbits-1:0]  tx_next;
  logic              ovr_next;

`ifdef SEC_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tmo_reg, tmo_cnt_next;
  logic          tmo_next;
`endif

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    p_abc_next = 3'b000;
    buf_next   = buf_out;
    tx_next    = tx_data;
    ovr_next   = 1'b0;
    tx_start   = 1'b0;
`ifdef SEC_TIMEOUT_EN
    tmo_cnt_next = '0;
    tmo_next     = 1'b0;
`endif

    case (state_reg)
      ESP_A: begin
        if (rx_valid) begin
          p_abc_next = 3'b100;
          buf_next   = rx_data;
          state_next = ESP_B;
        end
      end
      ESP_B: begin
        if (rx_valid) begin
          p_abc_next = 3'b010;
          buf_next   = rx_data;
          state_next = ESP_OP;
        end
      end
      ESP_OP: begin
        if (rx_valid) begin
          p_abc_next = 3'b001;
          buf_next   = rx_data;
          wait_next  = WW'(RES_WAIT);
          state_next = ESP_ALU;
        end
      end
      ESP_ALU: begin
        ovr_next = rx_valid;
        if (wait_reg == '0) begin
          tx_next    = dato_R;
          state_next = ENVIAR;
        end else begin
          wait_next = wait_reg - WW'(1);
        end
      end
      ENVIAR: begin
        ovr_next = rx_valid;
        // Mealy start so the pulse can never overlap a busy transmitter.
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = ESP_A;
        end
      end
      default: state_next = ESP_A;
    endcase

`ifdef SEC_TIMEOUT_EN
    // Idle count between bytes of a group; an accepted byte always wins over expiry.
    if ((state_reg == ESP_B || state_reg == ESP_OP) && !rx_valid) begin
      if (tmo_reg == TW'(TIMEOUT - 1)) begin
        state_next = ESP_A;
        tmo_next   = 1'b1;
      end else begin
        tmo_cnt_next = tmo_reg + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ESP_A;
      wait_reg  <= '0;
      p_abc     <= 3'b000;
      buf_out   <= '0;
      tx_data   <= '0;
      err_ovr   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      p_abc     <= p_abc_next;
      buf_out   <= buf_next;
      tx_data   <= tx_next;
      err_ovr   <= ovr_next;
    end
  end

`ifdef SEC_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_reg <= '0;
      err_tmo <= 1'b0;
    end else begin
      tmo_reg <= tmo_cnt_next;
      err_tmo <= tmo_next;
    end
  end
`else
  assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_secuenciador_alu.sv
// Directed bench for secuenciador_alu with a small ALU-handler model (ADD 0x20, SUB 0x22).
module tb_secuenciador_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [2:0] p_abc;
  logic [7:0] buf_out;
  logic [7:0] dato_R;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       err_ovr;
  logic       err_tmo;

  int vectors = 0;
  int miscompares = 0;

  secuenciador_alu #(.nbits(8), .RES_WAIT(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .p_abc(p_abc), .buf_out(buf_out), .dato_R(dato_R), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .err_ovr(err_ovr), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  // ALU handler model: no reset, captures on strobes, keeps 6 opcode bits.
  logic [7:0] a_m = '0, b_m = '0;
  logic [5:0] op_m = '0;
  always @(posedge clk) begin
    if (p_abc == 3'b100) a_m <= buf_out;
    if (p_abc == 3'b010) b_m <= buf_out;
    if (p_abc == 3'b001) op_m <= buf_out[5:0];
  end
  always_comb begin
    dato_R = 8'h00;
    if (op_m == 6'h20) dato_R = a_m + b_m;
    else if (op_m == 6'h22) dato_R = a_m - b_m;
  end

`ifdef SEC_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs applied just after the edge, outputs checked 2 time units later.
  task automatic cyc(input logic v, input logic [7:0] d, input logic busy);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
    tx_busy  = busy;
    #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_p_abc", 32'(p_abc), 32'h0);
    chk("rst_buf_out", 32'(buf_out), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_err_ovr", 32'(err_ovr), 32'h0);
    chk("rst_err_tmo", 32'(err_tmo), 32'h0);
    rst_n = 1'b1;

    // First byte after reset strobes A for exactly one cycle
    cyc(1'b1, 8'h05, 1'b0);
    chk("a_pre", 32'(p_abc), 32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("a_strobe", 32'(p_abc), 32'h4);
    chk("a_buf", 32'(buf_out), 32'h05);
    cyc(1'b0, 8'h00, 1'b0);
    chk("a_one_cycle", 32'(p_abc), 32'h0);
    chk("buf_hold", 32'(buf_out), 32'h05);
    $display("step: A=0x05 loaded after reset");

    // Asynchronous reset mid-group, then a fresh group restarts at A
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_buf", 32'(buf_out), 32'h0);
    chk("async_rst_p_abc", 32'(p_abc), 32'h0);
    #2 rst_n = 1'b1;

    // Back-to-back group 0x05, 0x03, 0x20 (ADD) -> 0x08
    cyc(1'b1, 8'h05, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    chk("t1_strobe_a", 32'(p_abc), 32'h4);
    chk("t1_buf_a", 32'(buf_out), 32'h05);
    cyc(1'b1, 8'h20, 1'b0);
    chk("t1_strobe_b", 32'(p_abc), 32'h2);
    chk("t1_buf_b", 32'(buf_out), 32'h03);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_strobe_op", 32'(p_abc), 32'h1);
    chk("t1_buf_op", 32'(buf_out), 32'h20);
    chk("t1_start_k", 32'(tx_start), 32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_start_k1", 32'(tx_start), 32'h0);
    chk("t1_p_abc_idle", 32'(p_abc), 32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_start_k2", 32'(tx_start), 32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_start_k3", 32'(tx_start), 32'h1);
    chk("t1_tx_data", 32'(tx_data), 32'h08);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_start_pulse", 32'(tx_start), 32'h0);
    chk("t1_tx_hold", 32'(tx_data), 32'h08);
    $display("txn: 05 03 20 -> result 0x%02h", tx_data);

    // Group 0x10, 0x22, 0x20 -> 0x32, with overrun byte and backpressure
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h20, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t2_strobe_op", 32'(p_abc), 32'h1);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("t2_ovr_pre", 32'(err_ovr), 32'h0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t2_err_ovr", 32'(err_ovr), 32'h1);
    chk("t2_ovr_no_strobe", 32'(p_abc), 32'h0);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("t2_busy_no_start", 32'(tx_start), 32'h0);
      if (i == 0) chk("t2_ovr_one_cycle", 32'(err_ovr), 32'h0);
    end
    chk("t2_tx_data_busy", 32'(tx_data), 32'h32);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_start", 32'(tx_start), 32'h1);
    chk("t2_tx_data", 32'(tx_data), 32'h32);
    $display("txn: 10 22 20 (busy 50, overrun 0xAA) -> result 0x%02h", tx_data);

    // Next group begins in the cycle ESP_A is re-entered: 0x0A, 0x02, 0x22 (SUB) -> 0x08
    cyc(1'b1, 8'h0A, 1'b0);
    chk("t3_start_pulse", 32'(tx_start), 32'h0);
    cyc(1'b1, 8'h02, 1'b0);
    chk("t3_strobe_a", 32'(p_abc), 32'h4);
    chk("t3_buf_a", 32'(buf_out), 32'h0A);
    cyc(1'b1, 8'h22, 1'b0);
    chk("t3_strobe_b", 32'(p_abc), 32'h2);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_strobe_op", 32'(p_abc), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_start", 32'(tx_start), 32'h1);
    chk("t3_tx_data", 32'(tx_data), 32'h08);
    $display("txn: 0A 02 22 -> result 0x%02h", tx_data);

    // Idle 20 cycles after the A byte
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h05, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("idle_no_tmo", 32'(err_tmo), 32'h0);
      if (i == 0) chk("idle_strobe_a", 32'(p_abc), 32'h4);
      else chk("idle_no_strobe", 32'(p_abc), 32'h0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_pulse", 32'(err_tmo), 32'(TMO_ON));
    chk("tmo_no_strobe", 32'(p_abc), 32'h0);
    cyc(1'b1, 8'h06, 1'b0);
    chk("tmo_one_cycle", 32'(err_tmo), 32'h0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("after_idle_strobe", 32'(p_abc), TMO_ON ? 32'h4 : 32'h2);
    chk("after_idle_buf", 32'(buf_out), 32'h06);
    $display("step: idle 20 then 0x06 -> p_abc=%b", p_abc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
